// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
//   Shared definitions for the instruction sequencer, the mipscpu datapath
//   and the benches: datapath widths, one-hot phase constants, opcode
//   encodings and the sequencer state type.
package cpu_sequencer_pkg;

    localparam int unsigned WORD_SIZE  = 16;
    localparam int unsigned OP_SIZE    = 4;
    localparam int unsigned TIMER_SIZE = 4;

    // One-hot phase values shown on `timer`
    localparam logic [TIMER_SIZE:0] CYCLE1 = 5'b00001;
    localparam logic [TIMER_SIZE:0] CYCLE2 = 5'b00010;
    localparam logic [TIMER_SIZE:0] CYCLE3 = 5'b00100;
    localparam logic [TIMER_SIZE:0] CYCLE4 = 5'b01000;
    localparam logic [TIMER_SIZE:0] CYCLE5 = 5'b10000;

    // Opcodes; the ALU ops double as the ALU `sel` encoding
    localparam logic [OP_SIZE-1:0] OP_ADD = 4'h0;
    localparam logic [OP_SIZE-1:0] OP_SUB = 4'h1;
    localparam logic [OP_SIZE-1:0] OP_AND = 4'h2;
    localparam logic [OP_SIZE-1:0] OP_OR  = 4'h3;
    localparam logic [OP_SIZE-1:0] OP_LI  = 4'h4;
    localparam logic [OP_SIZE-1:0] OP_BEQ = 4'h5;
    localparam logic [OP_SIZE-1:0] OP_JMP = 4'h6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_C1,
        ST_C2,
        ST_C3,
        ST_C4,
        ST_C5
    } seq_state_e;

    // True for ops that end with a register-file write
    function automatic logic op_writes_reg(input logic [OP_SIZE-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LI);
    endfunction

endpackage

// File: rtl/cpu_sequencer_instr_decode.sv
// instr_decode
//   Combinational split of a 16-bit instruction word into the fields the
//   sequencer needs per phase.
//   in : instr       instruction word
//   out: op          opcode field [15:12]
//        rd_addr     destination register index, zero-extended
//        src_a_addr  register read in C2 (operand A)
//        src_b_addr  register read in C3 (operand B)
//        imm8        zero-extended {rs,rt} for LI
//        imm4_sext   sign-extended [3:0] branch offset
//        jmp_target  zero-extended [11:0] jump target
//        alu_sel     ALU operation driven in C4
//        is_li, writes, branches, jumps  per-op flags
module instr_decode #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned OP_SIZE   = 4
) (
    input  logic [WORD_SIZE-1:0] instr,
    output logic [OP_SIZE-1:0]   op,
    output logic [WORD_SIZE-1:0] rd_addr,
    output logic [WORD_SIZE-1:0] src_a_addr,
    output logic [WORD_SIZE-1:0] src_b_addr,
    output logic [WORD_SIZE-1:0] imm8,
    output logic [WORD_SIZE-1:0] imm4_sext,
    output logic [WORD_SIZE-1:0] jmp_target,
    output logic [OP_SIZE-1:0]   alu_sel,
    output logic                 is_li,
    output logic                 writes,
    output logic                 branches,
    output logic                 jumps
);
    import cpu_sequencer_pkg::*;

    always_comb begin
        op         = instr[15:12];
        rd_addr    = WORD_SIZE'(instr[11:8]);
        imm8       = WORD_SIZE'(instr[7:0]);
        imm4_sext  = {{(WORD_SIZE-4){instr[3]}}, instr[3:0]};
        jmp_target = WORD_SIZE'(instr[11:0]);

        is_li      = (op == OP_LI);
        branches   = (op == OP_BEQ);
        jumps      = (op == OP_JMP);
        writes     = op_writes_reg(op);

        // BEQ keeps its offset in [3:0], so its two compared registers
        // are the [11:8] and [7:4] fields rather than rs/rt.
        if (branches) begin
            src_a_addr = WORD_SIZE'(instr[11:8]);
            src_b_addr = WORD_SIZE'(instr[7:4]);
        end else begin
            src_a_addr = WORD_SIZE'(instr[7:4]);
            src_b_addr = WORD_SIZE'(instr[3:0]);
        end

        if (is_li) begin
            alu_sel = OP_ADD;
        end else if (branches) begin
            alu_sel = OP_SUB;
        end else begin
            alu_sel = op;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Five-phase instruction sequencer driving the mipscpu control/data ports.
//   One instruction is started per falling edge of key_ok while idle.
//   in : clk, rst (sync, active-low), key_ok (active-low request),
//        instr (sampled on start), alu_out, alu_zero_flag, reg_data_out
//   out: timer (one-hot phase), data_1/data_2/sel (ALU operands/op),
//        data_in/load_pc/offset (PC update), reg_on/reg_w/reg_addr/
//        reg_data_in (register file), busy, done
//   All outputs are registered.
module cpu_sequencer #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned OP_SIZE    = 4,
    parameter int unsigned TIMER_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_ok,
    input  logic [WORD_SIZE-1:0]  instr,
    input  logic [WORD_SIZE-1:0]  alu_out,
    input  logic                  alu_zero_flag,
    input  logic [WORD_SIZE-1:0]  reg_data_out,
    output logic [TIMER_SIZE:0]   timer,
    output logic [WORD_SIZE-1:0]  data_1,
    output logic [WORD_SIZE-1:0]  data_2,
    output logic [OP_SIZE-1:0]    sel,
    output logic [WORD_SIZE-1:0]  data_in,
    output logic                  load_pc,
    output logic                  offset,
    output logic                  reg_on,
    output logic                  reg_w,
    output logic [WORD_SIZE-1:0]  reg_addr,
    output logic [WORD_SIZE-1:0]  reg_data_in,
    output logic                  busy,
    output logic                  done
);
    import cpu_sequencer_pkg::*;

    seq_state_e            state_q, state_d;
    logic                  key_q, key_d;
    logic                  arm_q, arm_d;
    logic [WORD_SIZE-1:0]  instr_q, instr_d;
    logic [WORD_SIZE-1:0]  a_q, a_d;

    logic [TIMER_SIZE:0]   timer_q, timer_d;
    logic [WORD_SIZE-1:0]  data_1_q, data_1_d;
    logic [WORD_SIZE-1:0]  data_2_q, data_2_d;
    logic [OP_SIZE-1:0]    sel_q, sel_d;
    logic [WORD_SIZE-1:0]  data_in_q, data_in_d;
    logic                  load_pc_q, load_pc_d;
    logic                  offset_q, offset_d;
    logic                  reg_on_q, reg_on_d;
    logic                  reg_w_q, reg_w_d;
    logic [WORD_SIZE-1:0]  reg_addr_q, reg_addr_d;
    logic [WORD_SIZE-1:0]  reg_data_in_q, reg_data_in_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [OP_SIZE-1:0]    dec_op;
    logic [WORD_SIZE-1:0]  dec_rd, dec_src_a, dec_src_b;
    logic [WORD_SIZE-1:0]  dec_imm8, dec_imm4_sext, dec_jmp_target;
    logic [OP_SIZE-1:0]    dec_alu_sel;
    logic                  dec_is_li, dec_writes, dec_branches, dec_jumps;
    logic                  start;

    instr_decode #(
        .WORD_SIZE (WORD_SIZE),
        .OP_SIZE   (OP_SIZE)
    ) u_decode (
        .instr      (instr_q),
        .op         (dec_op),
        .rd_addr    (dec_rd),
        .src_a_addr (dec_src_a),
        .src_b_addr (dec_src_b),
        .imm8       (dec_imm8),
        .imm4_sext  (dec_imm4_sext),
        .jmp_target (dec_jmp_target),
        .alu_sel    (dec_alu_sel),
        .is_li      (dec_is_li),
        .writes     (dec_writes),
        .branches   (dec_branches),
        .jumps      (dec_jumps)
    );

    // The history register resets to 1, which on its own would turn a key
    // held low through reset into a start on the first cycle out of reset.
    // arm_q blocks starts until key_ok has been seen released once.
    assign start = arm_q && key_q && !key_ok && (state_q == ST_IDLE);

    // Outputs are computed for the phase being entered, so each phase's
    // strobes are visible in the same cycle that timer shows that phase.
    // C5 outputs are computed from alu_out/alu_zero_flag at the end of C4,
    // which is where the ALU result is latched.
    always_comb begin
        state_d       = state_q;
        key_d         = key_ok;
        arm_d         = arm_q | key_ok;
        instr_d       = instr_q;
        a_d           = a_q;

        timer_d       = '0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        load_pc_d     = 1'b0;
        offset_d      = 1'b0;
        data_in_d     = '0;
        reg_on_d      = 1'b0;
        reg_w_d       = 1'b0;
        data_1_d      = data_1_q;
        data_2_d      = data_2_q;
        sel_d         = sel_q;
        reg_addr_d    = reg_addr_q;
        reg_data_in_d = reg_data_in_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_C1;
                    instr_d   = instr;
                    timer_d   = CYCLE1;
                    busy_d    = 1'b1;
                    load_pc_d = 1'b1;
                    offset_d  = 1'b1;
                    data_in_d = WORD_SIZE'(1);
                end
            end
            ST_C1: begin
                state_d    = ST_C2;
                timer_d    = CYCLE2;
                busy_d     = 1'b1;
                reg_on_d   = 1'b1;
                reg_addr_d = dec_src_a;
            end
            ST_C2: begin
                state_d    = ST_C3;
                timer_d    = CYCLE3;
                busy_d     = 1'b1;
                a_d        = reg_data_out;
                reg_on_d   = 1'b1;
                reg_addr_d = dec_src_b;
            end
            ST_C3: begin
                // Operand B goes straight into the registered data_2 output.
                state_d  = ST_C4;
                timer_d  = CYCLE4;
                busy_d   = 1'b1;
                sel_d    = dec_alu_sel;
                data_1_d = dec_is_li ? dec_imm8 : a_q;
                data_2_d = dec_is_li ? '0 : reg_data_out;
            end
            ST_C4: begin
                state_d = ST_C5;
                timer_d = CYCLE5;
                busy_d  = 1'b1;
                if (dec_writes) begin
                    reg_on_d      = 1'b1;
                    reg_w_d       = 1'b1;
                    reg_addr_d    = dec_rd;
                    reg_data_in_d = alu_out;
                end else if (dec_branches && alu_zero_flag) begin
                    load_pc_d = 1'b1;
                    offset_d  = 1'b1;
                    data_in_d = dec_imm4_sext;
                end else if (dec_jumps) begin
                    load_pc_d = 1'b1;
                    offset_d  = 1'b0;
                    data_in_d = dec_jmp_target;
                end
            end
            ST_C5: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            key_q         <= 1'b1;
            arm_q         <= 1'b0;
            instr_q       <= '0;
            a_q           <= '0;
            timer_q       <= '0;
            data_1_q      <= '0;
            data_2_q      <= '0;
            sel_q         <= '0;
            data_in_q     <= '0;
            load_pc_q     <= 1'b0;
            offset_q      <= 1'b0;
            reg_on_q      <= 1'b0;
            reg_w_q       <= 1'b0;
            reg_addr_q    <= '0;
            reg_data_in_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            arm_q         <= arm_d;
            instr_q       <= instr_d;
            a_q           <= a_d;
            timer_q       <= timer_d;
            data_1_q      <= data_1_d;
            data_2_q      <= data_2_d;
            sel_q         <= sel_d;
            data_in_q     <= data_in_d;
            load_pc_q     <= load_pc_d;
            offset_q      <= offset_d;
            reg_on_q      <= reg_on_d;
            reg_w_q       <= reg_w_d;
            reg_addr_q    <= reg_addr_d;
            reg_data_in_q <= reg_data_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign timer       = timer_q;
    assign data_1      = data_1_q;
    assign data_2      = data_2_q;
    assign sel         = sel_q;
    assign data_in     = data_in_q;
    assign load_pc     = load_pc_q;
    assign offset      = offset_q;
    assign reg_on      = reg_on_q;
    assign reg_w       = reg_w_q;
    assign reg_addr    = reg_addr_q;
    assign reg_data_in = reg_data_in_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Bench for cpu_sequencer. Surrounds the sequencer with a behavioural
//   register file and ALU, issues directed and random instructions, and
//   checks every phase against expectations derived from the instruction
//   semantics and a model register array.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_ok;
    logic [15:0] instr;
    logic [15:0] alu_out;
    logic        alu_zero_flag;
    logic [15:0] reg_data_out;
    logic [4:0]  timer;
    logic [15:0] data_1, data_2, data_in, reg_addr, reg_data_in;
    logic [3:0]  sel;
    logic        load_pc, offset, reg_on, reg_w, busy, done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [15:0] env_regs [16];   // register file seen by the DUT
    logic [15:0] mdl_regs [16];   // expected register contents

    always #5 clk = ~clk;

    cpu_sequencer #(
        .WORD_SIZE  (16),
        .OP_SIZE    (4),
        .TIMER_SIZE (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_ok        (key_ok),
        .instr         (instr),
        .alu_out       (alu_out),
        .alu_zero_flag (alu_zero_flag),
        .reg_data_out  (reg_data_out),
        .timer         (timer),
        .data_1        (data_1),
        .data_2        (data_2),
        .sel           (sel),
        .data_in       (data_in),
        .load_pc       (load_pc),
        .offset        (offset),
        .reg_on        (reg_on),
        .reg_w         (reg_w),
        .reg_addr      (reg_addr),
        .reg_data_in   (reg_data_in),
        .busy          (busy),
        .done          (done)
    );

    // Environment: combinational ALU and register-file read port
    always_comb begin
        case (sel)
            OP_ADD:  alu_out = data_1 + data_2;
            OP_SUB:  alu_out = data_1 - data_2;
            OP_AND:  alu_out = data_1 & data_2;
            OP_OR:   alu_out = data_1 | data_2;
            default: alu_out = 16'h0000;
        endcase
        alu_zero_flag = (alu_out == 16'h0000);
        reg_data_out  = env_regs[reg_addr[3:0]];
    end

    always @(posedge clk) begin
        if (reg_on && reg_w) env_regs[reg_addr[3:0]] <= reg_data_in;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and check all six cycles after the start edge.
    task automatic run_instr(input logic [15:0] iw, input bit press_mid, input bit abort_c4);
        logic [3:0]  op, f_rd, f_a, f_b;
        logic [15:0] a, b, exp_d1, exp_d2, exp_res, exp_din;
        logic [3:0]  exp_sel;
        bit          exp_w, exp_pc, exp_off;

        op   = iw[15:12];
        f_rd = iw[11:8];
        if (op == OP_BEQ) begin
            f_a = iw[11:8];
            f_b = iw[7:4];
        end else begin
            f_a = iw[7:4];
            f_b = iw[3:0];
        end
        a = mdl_regs[f_a];
        b = mdl_regs[f_b];

        exp_sel = op;
        exp_d1  = a;
        exp_d2  = b;
        if (op == OP_LI) begin
            exp_sel = OP_ADD;
            exp_d1  = {8'h00, iw[7:0]};
            exp_d2  = 16'h0000;
        end else if (op == OP_BEQ) begin
            exp_sel = OP_SUB;
        end

        case (op)
            OP_ADD:  exp_res = a + b;
            OP_SUB:  exp_res = a - b;
            OP_AND:  exp_res = a & b;
            OP_OR:   exp_res = a | b;
            OP_LI:   exp_res = {8'h00, iw[7:0]};
            default: exp_res = 16'h0000;
        endcase
        exp_w   = (op <= OP_LI);
        exp_off = (op == OP_BEQ) && (a == b);
        exp_pc  = exp_off || (op == OP_JMP);
        exp_din = exp_off ? {{12{iw[3]}}, iw[3:0]} :
                  (op == OP_JMP) ? {4'h0, iw[11:0]} : 16'h0000;

        @(negedge clk);
        key_ok = 1'b0;
        instr  = iw;
        tick();
        check_eq("c1_timer", timer, CYCLE1);
        check_eq("c1_busy", busy, 1);
        check_eq("c1_pc", {load_pc, offset}, 2'b11);
        check_eq("c1_data_in", data_in, 16'h0001);
        check_eq("c1_reg_on", reg_on, 0);

        @(negedge clk);
        key_ok = 1'b1;
        instr  = 16'($urandom);
        tick();
        check_eq("c2_timer", timer, CYCLE2);
        check_eq("c2_reg_on", {reg_on, reg_w}, 2'b10);
        check_eq("c2_reg_addr", reg_addr, {12'h000, f_a});
        check_eq("c2_pc", {load_pc, data_in}, 17'h0);

        tick();
        check_eq("c3_timer", timer, CYCLE3);
        check_eq("c3_reg_on", {reg_on, reg_w}, 2'b10);
        check_eq("c3_reg_addr", reg_addr, {12'h000, f_b});
        if (press_mid) begin
            @(negedge clk);
            key_ok = 1'b0;
        end

        tick();
        check_eq("c4_timer", timer, CYCLE4);
        check_eq("c4_sel", sel, exp_sel);
        check_eq("c4_data_1", data_1, exp_d1);
        check_eq("c4_data_2", data_2, exp_d2);
        check_eq("c4_reg_on", reg_on, 0);
        if (press_mid) begin
            @(negedge clk);
            key_ok = 1'b1;
        end

        if (abort_c4) begin
            @(negedge clk);
            rst = 1'b0;
            tick();
            check_eq("abort_ctl", {timer, busy, done, load_pc, offset, reg_on, reg_w}, 0);
            check_eq("abort_data", {data_1, data_2}, 0);
            check_eq("abort_misc", {sel, data_in, reg_addr, reg_data_in}, 0);
            @(negedge clk);
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                check_eq("post_abort", {timer, busy, reg_w, load_pc}, 0);
            end
            return;
        end

        tick();
        check_eq("c5_timer", timer, CYCLE5);
        check_eq("c5_reg_w", {reg_on, reg_w}, {exp_w, exp_w});
        check_eq("c5_pc", {load_pc, offset}, {exp_pc, exp_off});
        check_eq("c5_data_in", data_in, exp_din);
        if (exp_w) begin
            check_eq("c5_reg_addr", reg_addr, {12'h000, f_rd});
            check_eq("c5_reg_data", reg_data_in, exp_res);
            mdl_regs[f_rd] = exp_res;
        end

        tick();
        check_eq("done_pulse", {done, busy, timer}, {2'b10, 5'b00000});
        check_eq("done_strobes", {reg_w, load_pc, data_in}, 0);
        if (press_mid) begin
            tick();
            check_eq("ignored_press", {done, busy, timer}, 0);
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] iw;
        rst    = 1'b0;
        key_ok = 1'b0;
        instr  = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            mdl_regs[i] = v;
            env_regs[i] = v;
        end
        mdl_regs[1] = 16'd4; env_regs[1] = 16'd4;
        mdl_regs[2] = 16'd5; env_regs[2] = 16'd5;

        // Reset with key held low, then release: nothing may start.
        repeat (3) tick();
        check_eq("rst_ctl", {timer, busy, done, load_pc, offset, reg_on, reg_w}, 0);
        check_eq("rst_data", {data_1, data_2, sel, data_in, reg_addr, reg_data_in}, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("held_key", {timer, busy, done}, 0);
        end
        @(negedge clk);
        key_ok = 1'b1;
        repeat (2) tick();

        // Directed cases; consecutive calls also exercise start-on-done.
        run_instr(16'h0312, 1'b0, 1'b0);   // ADD r3,r1,r2
        run_instr(16'h47A5, 1'b0, 1'b0);   // LI r7,0xA5
        run_instr(16'h511E, 1'b0, 1'b0);   // BEQ r1,r1,-2 (taken)
        run_instr(16'h512E, 1'b0, 1'b0);   // BEQ r1,r2,-2 (not taken)
        run_instr(16'h6123, 1'b0, 1'b0);   // JMP 0x123
        run_instr(16'h1412, 1'b1, 1'b0);   // SUB r4,r1,r2 with press in C3
        run_instr(16'h0512, 1'b0, 1'b1);   // ADD r5,r1,r2 reset in C4
        @(negedge clk);
        key_ok = 1'b1;
        repeat (2) tick();

        // Random instructions with random idle gaps
        for (int n = 0; n < 60; n++) begin
            iw = 16'($urandom);
            if ($urandom_range(0, 3) != 0) iw[15:12] = 4'($urandom_range(0, 6));
            run_instr(iw, 1'b0, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                check_eq("idle_gap", {timer, busy}, 0);
            end
        end

        repeat (2) tick();
        for (int i = 0; i < 16; i++) check_eq($sformatf("regfile_r%0d", i), env_regs[i], mdl_regs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Hardware instruction sequencer that drives the `mipscpu` control and data ports, taking the place the bench stimulus occupies today. It accepts one 16-bit instruction word per `key_ok` press. Each instruction runs through a fixed five-phase cycle that fetches, reads operands from the register file, executes on the ALU, then writes back or branches. It emits the one-hot `timer` phase that the CPU datapath and the observers key on.

## Interface
Parameters:
- `WORD_SIZE`, 16, datapath and register-file word width
- `OP_SIZE`, 4, ALU select width; opcode field width
- `TIMER_SIZE`, 4, `timer` is `TIMER_SIZE+1` bits one-hot

Ports:
- `clk`  in  1  system clock; everything is on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `key_ok`  in  1  active-low request, already synchronised; a 1→0 transition starts one instruction
- `instr`  in  WORD_SIZE  instruction word, sampled on the start edge
- `alu_out`  in  WORD_SIZE  ALU result, combinational from `data_1`/`data_2`/`sel`
- `alu_zero_flag`  in  1  `alu_out == 0`
- `reg_data_out`  in  WORD_SIZE  register-file read data, combinational from `reg_addr`
- `timer`  out  TIMER_SIZE+1  one-hot phase, 0 when idle
- `data_1`, `data_2`  out  WORD_SIZE  ALU operands
- `sel`  out  OP_SIZE  ALU operation
- `data_in`  out  WORD_SIZE  PC load value or increment
- `load_pc`, `offset`  out  1  PC update strobe; 1 = `pc += data_in`, 0 = `pc = data_in`
- `reg_on`, `reg_w`  out  1  register-file enable; write strobe
- `reg_addr`, `reg_data_in`  out  WORD_SIZE  register address (zero-extended 4-bit index); write data
- `busy`  out  1  high from the start edge until the last phase completes
- `done`  out  1  one-cycle pulse after `CYCLE5`

## Operation
- Instruction fields: `[15:12]` op, `[11:8]` rd, `[7:4]` rs, `[3:0]` rt/imm4.
- Ops:
  - `ADD`, `SUB`, `AND`, `OR`: rd = rs op rt.
  - `LI`: rd = zero-extended `{rs,rt}` (8 bits); `sel=ADD`, `data_2=0`, `data_1=imm`.
  - `BEQ`: executes as `SUB` of rs and rt; if the zero flag is set, pc += sign-extended imm4.
  - `JMP`: pc = zero-extended `instr[11:0]`.
  - Any other op is a NOP: all phases run, with no write and no branch.
- Start is detected when `key_ok` was 1 last cycle and is 0 this cycle, and the block is not busy. Presses while busy are ignored and are not queued.
- FSM: `IDLE → C1 → C2 → C3 → C4 → C5 → IDLE`, one clock per phase. `timer` = `CYCLE1..CYCLE5` (bit 0..4).
  - **C1 (fetch):** `load_pc=1`, `offset=1`, `data_in=1`.
  - **C2:** `reg_on=1`, `reg_addr=rs`; latch `reg_data_out` into operand A.
  - **C3:** `reg_on=1`, `reg_addr=rt`; latch operand B.
  - **C4:** drive `data_1=A`, `data_2=B`, `sel=op`; latch `alu_out` and `alu_zero_flag`.
  - **C5:**
    - ALU/LI ops: `reg_on=1`, `reg_w=1`, `reg_addr=rd`, `reg_data_in` = latched result.
    - BEQ taken: `load_pc=1`, `offset=1`, `data_in=sext(imm4)`.
    - JMP: `load_pc=1`, `offset=0`, `data_in=instr[11:0]`.
- Strobes are asserted only in their phase. `data_*`, `sel`, and `reg_addr` hold their last value outside their phase; `data_in` is 0 outside phases.
- Arithmetic is modulo 2^WORD_SIZE. The relative branch wraps PC naturally.
- A write to r0 is performed like any other write; no register is hardwired.

## Timing
- Reset (`rst=0` at an edge): FSM goes to IDLE and every output goes to 0, including `timer`, `busy`, and `done`. The `key_ok` history register is set to 1, so a key held low through reset does not start an instruction.
- Reset mid-instruction aborts immediately. No write or PC update occurs in the cycle of reset or after it.
- Latency: start edge at cycle N, `C1` at N+1, `C5` at N+5, `done` at N+6. Minimum spacing between instructions is 6 cycles.
- All outputs are registered. Phase outputs appear in the same cycle that `timer` shows the phase.
- `done` can coincide with a new start edge: that start is accepted and `C1` follows on the next cycle.

## Structure
- Shared package/header: `WORD_SIZE`, `OP_SIZE`, `TIMER_SIZE`, the `CYCLE1..CYCLE5` one-hot constants, and the opcode constants `ADD/SUB/AND/OR/LI/BEQ/JMP`. The CPU and the benches use the same definitions.
- One sub-module: `instr_decode`, combinational, covering field split, immediate extension, and the writes/branches/jumps flags.

## Test plan
- Reset with `key_ok` held 0, then release `rst`: all outputs 0 and no `C1` appears.
- r1=4, r2=5 preloaded; `instr=ADD r3,r1,r2` (16'h0312) with a key press: `C4` shows `sel=ADD`, `data_1=4`, `data_2=5`; `C5` shows `reg_w=1`, `reg_addr=3`, `reg_data_in=9`; `done` at N+6.
- `LI r7,0xA5` (op LI, rd=7, imm=8'hA5): `C5` writes 16'h00A5 to r7.
- `BEQ r1,r1,-2` (imm4=4'hE): `C5` shows `load_pc=1`, `offset=1`, `data_in=16'hFFFE`. With r1=4, r2=5, `BEQ r1,r2,-2`: no PC load in `C5`.
- `JMP 0x123`: `C5` shows `load_pc=1`, `offset=0`, `data_in=16'h0123`.
- A second `key_ok` press during `C3`: it is ignored and exactly one `done` pulse occurs. `rst=0` during `C4`: no `reg_w` follows and all outputs are 0 on the next edge.
